// File: rtl/ps2_kbd_decoder_pkg.sv
// rtl/ps2_kbd_decoder_pkg.sv - shared state encoding, scan constants and event type
package ps2_kbd_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        EXT     = ST_EXT,
        BRK     = ST_BRK,
        EXT_BRK = ST_EXT_BRK
    } state_t;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_FAKE   = 8'h7C;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
        logic [7:0] ascii;
    } key_evt_t;

    // Keyboard status/ack bytes that never represent a key
    function automatic logic is_ignored(input logic [7:0] code);
        return code inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1};
    endfunction

endpackage

// File: rtl/ps2_kbd_decoder_if.sv
// rtl/ps2_kbd_decoder_if.sv - receiver byte stream in, key event FIFO and status out
interface ps2_kbd_decoder_if;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rd_en;
    logic       key_valid;
    logic [7:0] key_ascii;
    logic [7:0] key_code;
    logic       key_ext;
    logic       shift_on;
    logic       caps_on;
    logic       fifo_full;
    logic       overflow;

    modport master (
        output rx_done_tick, rx_data, rd_en,
        input  key_valid, key_ascii, key_code, key_ext,
        input  shift_on, caps_on, fifo_full, overflow
    );

    modport slave (
        input  rx_done_tick, rx_data, rd_en,
        output key_valid, key_ascii, key_code, key_ext,
        output shift_on, caps_on, fifo_full, overflow
    );
endinterface

// File: rtl/ps2_kbd_decoder_scan2ascii.sv
// rtl/ps2_kbd_decoder_scan2ascii.sv - combinational set-2 make code to US ASCII ROM
module ps2_scan2ascii (
    input  logic [7:0] code,
    input  logic       shift_on,
    input  logic       caps_on,
    output logic [7:0] ascii
);
    logic [7:0] lower;
    logic [7:0] base;
    logic [7:0] shifted;

    always_comb begin
        lower   = 8'h00;
        base    = 8'h00;
        shifted = 8'h00;
        case (code)
            8'h1C: lower = "a";  8'h32: lower = "b";  8'h21: lower = "c";  8'h23: lower = "d";
            8'h24: lower = "e";  8'h2B: lower = "f";  8'h34: lower = "g";  8'h33: lower = "h";
            8'h43: lower = "i";  8'h3B: lower = "j";  8'h42: lower = "k";  8'h4B: lower = "l";
            8'h3A: lower = "m";  8'h31: lower = "n";  8'h44: lower = "o";  8'h4D: lower = "p";
            8'h15: lower = "q";  8'h2D: lower = "r";  8'h1B: lower = "s";  8'h2C: lower = "t";
            8'h3C: lower = "u";  8'h2A: lower = "v";  8'h1D: lower = "w";  8'h22: lower = "x";
            8'h35: lower = "y";  8'h1A: lower = "z";
            8'h16: {base, shifted} = "1!";
            8'h1E: {base, shifted} = "2@";
            8'h26: {base, shifted} = "3#";
            8'h25: {base, shifted} = "4$";
            8'h2E: {base, shifted} = "5%";
            8'h36: {base, shifted} = "6^";
            8'h3D: {base, shifted} = "7&";
            8'h3E: {base, shifted} = "8*";
            8'h46: {base, shifted} = "9(";
            8'h45: {base, shifted} = "0)";
            8'h4E: {base, shifted} = "-_";
            8'h55: {base, shifted} = "=+";
            8'h0E: {base, shifted} = "`~";
            8'h54: {base, shifted} = "[{";
            8'h5B: {base, shifted} = "]}";
            8'h5D: {base, shifted} = {8'h5C, 8'h7C};
            8'h4C: {base, shifted} = ";:";
            8'h52: {base, shifted} = {8'h27, 8'h22};
            8'h41: {base, shifted} = ",<";
            8'h49: {base, shifted} = ".>";
            8'h4A: {base, shifted} = "/?";
            8'h29: {base, shifted} = "  ";
            8'h5A: {base, shifted} = {8'h0D, 8'h0D};
            8'h66: {base, shifted} = {8'h08, 8'h08};
            8'h0D: {base, shifted} = {8'h09, 8'h09};
            8'h76: {base, shifted} = {8'h1B, 8'h1B};
            default: ;
        endcase
    end

    // Letters follow shift XOR caps; everything else follows shift alone
    always_comb begin
        ascii = 8'h00;
        if (lower != 8'h00)
            ascii = (shift_on ^ caps_on) ? (lower - 8'h20) : lower;
        else
            ascii = shift_on ? shifted : base;
    end
endmodule

// File: rtl/ps2_kbd_decoder.sv
// rtl/ps2_kbd_decoder.sv - PS/2 set-2 scan byte decoder with prefix FSM and show-ahead key FIFO
module ps2_kbd_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int          DEPTH   = 8,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic               clk,
    input  logic               reset,
    ps2_kbd_decoder_if.slave   bus
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    state_t      state, state_nxt;
    logic [15:0] tmo_cnt;
    logic        tick, timeout_hit;
    logic [7:0]  b, ascii;
    logic        lshift, rshift, caps, caps_held, shift_on;
    logic        push, push_ext;
    logic        lshift_set, lshift_clr, rshift_set, rshift_clr, caps_press, caps_rel;

    assign tick        = bus.rx_done_tick;
    assign b           = bus.rx_data;
    assign shift_on    = lshift | rshift;
    assign timeout_hit = (state != IDLE) && !tick && (tmo_cnt == TIMEOUT - 16'd1);

    ps2_scan2ascii u_scan2ascii (
        .code     (b),
        .shift_on (shift_on),
        .caps_on  (caps),
        .ascii    (ascii)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        push       = 1'b0;
        push_ext   = 1'b0;
        lshift_set = 1'b0;
        lshift_clr = 1'b0;
        rshift_set = 1'b0;
        rshift_clr = 1'b0;
        caps_press = 1'b0;
        caps_rel   = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (b == SC_EXT)         state_nxt = EXT;
                    else if (b == SC_BRK)    state_nxt = BRK;
                    else if (is_ignored(b))  state_nxt = IDLE;
                    else if (b == SC_LSHIFT) lshift_set = 1'b1;
                    else if (b == SC_RSHIFT) rshift_set = 1'b1;
                    else if (b == SC_CAPS)   caps_press = 1'b1;
                    else                     push = 1'b1;
                end
                EXT: begin
                    if (b == SC_BRK) begin
                        state_nxt = EXT_BRK;
                    end else begin
                        state_nxt = IDLE;
                        // E0 12 / E0 7C are fake-shift bytes around extended keys
                        if (b != SC_LSHIFT && b != SC_FAKE) begin
                            push     = 1'b1;
                            push_ext = 1'b1;
                        end
                    end
                end
                BRK: begin
                    state_nxt  = IDLE;
                    lshift_clr = (b == SC_LSHIFT);
                    rshift_clr = (b == SC_RSHIFT);
                    caps_rel   = (b == SC_CAPS);
                end
                default: state_nxt = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            tmo_cnt <= 16'd0;
        else if (tick || state_nxt == IDLE)    tmo_cnt <= 16'd0;
        else                                   tmo_cnt <= tmo_cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            caps      <= 1'b0;
            caps_held <= 1'b0;
        end else begin
            if (lshift_set)      lshift <= 1'b1;
            else if (lshift_clr) lshift <= 1'b0;
            if (rshift_set)      rshift <= 1'b1;
            else if (rshift_clr) rshift <= 1'b0;
            // caps_held suppresses re-toggling on typematic repeats
            if (caps_press) begin
                if (!caps_held) caps <= ~caps;
                caps_held <= 1'b1;
            end else if (caps_rel) begin
                caps_held <= 1'b0;
            end
        end
    end

    key_evt_t            evt_q;
    logic                push_q;
    key_evt_t            mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic                full, pop, do_push;
    key_evt_t            head;

    assign full    = (count == FULL_CNT);
    assign pop     = bus.rd_en && (count != '0);
    assign do_push = push_q && (!full || pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push_q <= 1'b0;
            evt_q  <= '0;
        end else begin
            push_q <= push;
            evt_q  <= '{ext: push_ext, code: b, ascii: push_ext ? 8'h00 : ascii};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= evt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bus.overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (push_q && full && !pop) bus.overflow <= 1'b1;
        end
    end

    assign bus.key_valid = (count != '0);
    assign bus.key_ascii = bus.key_valid ? head.ascii : 8'h00;
    assign bus.key_code  = bus.key_valid ? head.code  : 8'h00;
    assign bus.key_ext   = bus.key_valid ? head.ext   : 1'b0;
    assign bus.shift_on  = shift_on;
    assign bus.caps_on   = caps;
    assign bus.fifo_full = full;
endmodule
